sha3_burst_feeder: RTL and testbench
====================================

Name: sha3_burst_feeder

Overview:
- Producer/consumer front end for the iterating SHA3 pipe core (gimme/sample/good protocol).
- Accepts 1600-bit Keccak states one per valid/ready beat and collects a burst of BURST states.
- When the core raises gimme, streams that burst into the core with sample held high for exactly BURST consecutive clocks.
- Captures the BURST result matrices the core returns under good, then drains them downstream in issue order.

Parameters:
- BURST, 15, states per burst; equals the core's burst length; range 2..32.
- IDXW, $clog2(BURST+1), width of slot and count indices.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream state available.
- in_ready  out  1  feeder accepts a state this cycle.
- in_state  in  64 x25  state lanes, index x+5*y.
- in_flush  in  1  launch a partial burst now; sampled only when in_valid=0.
- core_gimme  in  1  core can take a new burst.
- core_sample  out  1  driven high for BURST consecutive cycles per launch.
- core_in  out  64 x25  matrix presented to the core while core_sample=1.
- core_good  in  1  core result valid this cycle.
- core_out  in  64 x25  core result matrix.
- out_valid  out  1  result state available.
- out_ready  in  1  downstream takes the result.
- out_state  out  64 x25  result lanes.
- out_last  out  1  final real result of the burst.
- busy  out  1  state != FILL, or fill count != 0.
- err_overrun  out  1  sticky; core_good seen outside WAIT_RES.

Behaviour:
- Storage: one buffer of BURST slots x 1600 bits. Results overwrite the slot their source came from.
- Reset (async, rst_n=0):
  - state=FILL; counts=0; err_overrun=0.
  - core_sample=0, out_valid=0, out_last=0, in_ready=1, core_in=0.
  - Slot contents are don't-care.
- Reset mid-burst abandons all data. Core-side recovery is the core's concern.
- FILL:
  - in_ready=1.
  - Each in_valid&in_ready beat writes slot[n_real] and increments n_real.
  - Go to LAUNCH on either:
    - n_real reaches BURST (same edge as the final write); or
    - in_flush=1 with in_valid=0 and n_real>0.
  - in_flush with n_real=0 is ignored.
  - Slots n_real..BURST-1 are zero-padded: their write enables are forced with zero data on the LAUNCH transition edge.
- LAUNCH:
  - in_ready=0.
  - Wait for core_gimme=1 at a clock edge.
  - On the next cycle, core_sample=1 and core_in=slot[0].
  - Continue for cycles k=0..BURST-1 with core_in=slot[k]. Registered outputs; no gaps.
  - After cycle BURST-1: core_sample=0, go to WAIT_RES.
  - core_gimme is ignored while issuing.
- WAIT_RES:
  - Each cycle core_good=1 writes core_out into slot[r] and increments r.
  - Gaps between good cycles are allowed.
  - When r reaches BURST (edge of the last capture), go to DRAIN with d=0.
- DRAIN:
  - out_valid=1 and out_state=slot[d] while d<n_real.
  - out_last=1 when d=n_real-1.
  - Each out_valid&out_ready beat increments d.
  - On the last beat: go to FILL, clear n_real/r/d, out_valid=0 next cycle.
  - Padded results are captured but never emitted.
  - out_state is stable while out_valid=1 and out_ready=0.
- Protocol faults:
  - core_good=1 in FILL, LAUNCH or DRAIN sets err_overrun (sticky until reset); data is discarded.
  - r never exceeds BURST.
- Simultaneous events:
  - In FILL, the final accept and the LAUNCH transition occur on the same edge.
  - core_gimme=1 on the transition edge into LAUNCH is not seen. gimme is sampled from the first LAUNCH cycle on.
- Latency from LAUNCH entry with gimme already high: core_sample rises 2 cycles after the LAUNCH transition edge.
- Throughput: strictly one burst in flight. The next FILL begins only after DRAIN completes.

Test Plan:
- Full burst:
  - Stimulus: 15 states, lane0 = 1..15, others 0; gimme high; core model returns lane0+0x100 under 15 contiguous good cycles.
  - Response: core_sample high exactly 15 cycles with lane0 1..15 in order; out lane0 0x101..0x10F; out_last on 0x10F only.
- Flush partial:
  - Stimulus: 3 states (lane0 = 7,8,9), then in_flush.
  - Response: core_in lane0 = 7,8,9,0 x12 over 15 sample cycles; after 15 goods, exactly 3 outputs; out_last on the third.
- Gimme stall:
  - Stimulus: hold gimme low 20 cycles after LAUNCH entry.
  - Response: core_sample stays 0; it rises exactly 1 cycle after the first edge with gimme=1.
- Gapped results and backpressure:
  - Stimulus: good asserted in 4 separated bursts (5,5,3,2); out_ready toggled 1-0-1.
  - Response: all 15 captured correctly; out_state held stable while out_ready=0; in_ready=0 until the last drain beat.
- Overrun:
  - Stimulus: pulse core_good during FILL.
  - Response: err_overrun=1 next cycle and stays 1; buffer contents unaffected.
- Async reset:
  - Stimulus: assert rst_n=0 mid-LAUNCH (cycle 6 of 15).
  - Response: core_sample=0 immediately; after release, in_ready=1, busy=0, err_overrun=0.

Source files
------------

// File: rtl/sha3_burst_feeder.sv
// sha3_burst_feeder: collects a burst of BURST Keccak states from upstream, streams
// them into the iterating SHA3 core (gimme/sample/good), captures the BURST results
// back into the same slots and drains the real (non-padded) ones downstream in order.
// Ports: in_valid/in_ready/in_state/in_flush  upstream states, in_flush launches a partial burst
//        core_gimme/core_sample/core_in        burst issue to the core, sample high BURST clocks
//        core_good/core_out                    results returned by the core
//        out_valid/out_ready/out_state/out_last downstream results, out_last on final real one
//        busy, err_overrun                     activity flag, sticky stray-result flag
// Latency: core_sample rises 2 clocks after entering LAUNCH when gimme is already high.
// Backpressure: in_ready low outside FILL; out_state is held while out_ready is low.
module sha3_burst_feeder #(
  parameter int BURST = 15,
  parameter int IDXW  = $clog2(BURST + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1599:0] in_state,
  input  logic          in_flush,
  input  logic          core_gimme,
  output logic          core_sample,
  output logic [1599:0] core_in,
  input  logic          core_good,
  input  logic [1599:0] core_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1599:0] out_state,
  output logic          out_last,
  output logic          busy,
  output logic          err_overrun
);

  localparam logic [IDXW-1:0] ONE     = IDXW'(1);
  localparam logic [IDXW-1:0] LAST    = IDXW'(BURST - 1);
  localparam logic [IDXW-1:0] BURST_I = IDXW'(BURST);

  // LAUNCH waits for gimme; ISSUE is the registered sample window that follows it.
  typedef enum logic [2:0] {
    FILL     = 3'd0,
    LAUNCH   = 3'd1,
    ISSUE    = 3'd2,
    WAIT_RES = 3'd3,
    DRAIN    = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [IDXW-1:0] n_real;   // real states collected
  logic [IDXW-1:0] k_idx;    // next slot to issue
  logic [IDXW-1:0] r_idx;    // next slot to capture
  logic [IDXW-1:0] d_idx;    // next slot to drain
  logic [1599:0]   slot [BURST];

  logic accept, fill_done, flush_go, gimme_go, issue_done;
  logic cap, res_done, drain_beat, last_beat;

  assign accept     = (state == FILL) && in_valid;
  assign fill_done  = accept && (n_real == LAST);
  assign flush_go   = (state == FILL) && !in_valid && in_flush && (n_real != '0);
  assign gimme_go   = (state == LAUNCH) && core_gimme;
  assign issue_done = (state == ISSUE) && (k_idx == BURST_I);
  assign cap        = (state == WAIT_RES) && core_good;
  assign res_done   = cap && (r_idx == LAST);
  assign drain_beat = (state == DRAIN) && out_ready;
  assign last_beat  = drain_beat && ((d_idx + ONE) == n_real);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FILL:     if (fill_done || flush_go) state_nx = LAUNCH;
      LAUNCH:   if (gimme_go)              state_nx = ISSUE;
      ISSUE:    if (issue_done)            state_nx = WAIT_RES;
      WAIT_RES: if (res_done)              state_nx = DRAIN;
      DRAIN:    if (last_beat)             state_nx = FILL;
      default:                             state_nx = FILL;
    endcase
  end

  // Slot storage has no reset: contents are only consumed after being written.
  // Flush zero-pads every slot from n_real upward on the same edge as the LAUNCH move.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BURST; i++) begin
      if (accept && (n_real == IDXW'(i)))
        slot[i] <= in_state;
      else if (flush_go && (IDXW'(i) >= n_real))
        slot[i] <= '0;
      else if (cap && (r_idx == IDXW'(i)))
        slot[i] <= core_out;
    end
  end

  // Issue window: one slot per clock, registered, no gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_sample <= 1'b0;
      core_in     <= '0;
      k_idx       <= '0;
    end else if ((state == ISSUE) && (k_idx != BURST_I)) begin
      core_sample <= 1'b1;
      core_in     <= slot[k_idx];
      k_idx       <= k_idx + ONE;
    end else begin
      core_sample <= 1'b0;
      core_in     <= '0;
      k_idx       <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_real      <= '0;
      r_idx       <= '0;
      d_idx       <= '0;
      err_overrun <= 1'b0;
    end else begin
      if (last_beat)   n_real <= '0;
      else if (accept) n_real <= n_real + ONE;

      if (last_beat)   r_idx <= '0;
      else if (cap)    r_idx <= r_idx + ONE;

      if (last_beat)       d_idx <= '0;
      else if (drain_beat) d_idx <= d_idx + ONE;

      // Results arriving outside the capture window are dropped and flagged.
      if (core_good && (state != WAIT_RES)) err_overrun <= 1'b1;
    end
  end

  assign in_ready  = (state == FILL);
  assign out_valid = (state == DRAIN);
  assign out_state = slot[d_idx];
  assign out_last  = out_valid && ((d_idx + ONE) == n_real);
  assign busy      = (state != FILL) || (n_real != '0);

endmodule

// File: tb/tb_sha3_burst_feeder.sv
module tb_sha3_burst_feeder;
  localparam int BURST = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1599:0] in_state = '0;
  logic          in_flush = 1'b0;
  logic          core_gimme = 1'b0;
  logic          core_sample;
  logic [1599:0] core_in;
  logic          core_good = 1'b0;
  logic [1599:0] core_out = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1599:0] out_state;
  logic          out_last;
  logic          busy;
  logic          err_overrun;

  always #5 clk = ~clk;

  sha3_burst_feeder #(.BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_flush(in_flush),
    .core_gimme(core_gimme), .core_sample(core_sample), .core_in(core_in),
    .core_good(core_good), .core_out(core_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .out_last(out_last),
    .busy(busy), .err_overrun(err_overrun)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [1599:0] exp_in[$];
  logic exp_err = 1'b0;

  task automatic chk(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got low=%h expected low=%h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  // Stand-in for the core: every lane gets a lane-specific offset.
  function automatic logic [1599:0] core_fn(input logic [1599:0] x);
    logic [1599:0] y;
    for (int l = 0; l < 25; l++) y[64*l +: 64] = x[64*l +: 64] + 64'h100 + 64'(l);
    return y;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input int n, input int gd, input bit directed, input int base,
                           input bit gaps, input bit ovr);
    logic [1599:0] s;
    int stalls;
    int d;
    exp_in.delete();
    for (int i = 0; i < n; i++) begin
      s = '0;
      if (directed) s[63:0] = 64'(base + i);
      else for (int l = 0; l < 25; l++) s[64*l +: 64] = {$urandom, $urandom};
      exp_in.push_back(s);
    end
    for (int i = n; i < BURST; i++) exp_in.push_back('0);

    core_gimme = 1'($urandom_range(0, 1));
    if (!directed) begin
      in_flush = 1'b1; tick; in_flush = 1'b0;
      chk("flush_empty_ignored", in_ready, 1);
      chk("flush_empty_busy", busy, 0);
    end
    for (int i = 0; i < n; i++) begin
      if (!directed && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; tick;
      end
      chk("fill_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_state = exp_in[i];
      in_flush = directed ? 1'b0 : 1'($urandom_range(0, 1));
      tick;
      in_valid = 1'b0;
      in_flush = 1'b0;
      if (ovr && i == 1 && n > 2) begin
        core_good = 1'b1; core_out = {50{$urandom}}; tick; core_good = 1'b0;
        exp_err = 1'b1;
        chk("overrun_set", err_overrun, 1);
      end
    end
    if (n < BURST) begin
      in_flush = 1'b1; tick; in_flush = 1'b0;
    end
    chk("launch_in_ready", in_ready, 0);
    chk("launch_busy", busy, 1);

    if (gd > 0) begin
      core_gimme = 1'b0;
      for (int i = 0; i < gd; i++) begin
        tick;
        chk("stall_sample", core_sample, 0);
      end
    end
    core_gimme = 1'b1;
    tick;
    chk("gimme_edge_sample", core_sample, 0);
    core_gimme = 1'($urandom_range(0, 1));
    tick;
    for (int k = 0; k < BURST; k++) begin
      chk("issue_sample", core_sample, 1);
      chk("issue_data", core_in, exp_in[k]);
      core_gimme = 1'($urandom_range(0, 1));
      tick;
    end
    chk("issue_end", core_sample, 0);
    core_gimme = 1'b0;

    for (int k = 0; k < BURST; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        core_good = 1'b0;
        repeat ($urandom_range(1, 3)) tick;
        chk("wait_no_out", out_valid, 0);
      end
      core_good = 1'b1;
      core_out  = core_fn(exp_in[k]);
      tick;
    end
    core_good = 1'b0;

    d = 0;
    stalls = 0;
    while (d < n) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_state, core_fn(exp_in[d]));
      chk("drain_last", out_last, (d == n - 1));
      chk("drain_in_ready", in_ready, 0);
      out_ready = (stalls >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      if (out_ready) begin
        d++;
        stalls = 0;
      end else begin
        stalls++;
      end
      tick;
    end
    out_ready = 1'b0;
    chk("done_valid", out_valid, 0);
    chk("done_in_ready", in_ready, 1);
    chk("done_busy", busy, 0);
    chk("err_state", err_overrun, exp_err);
  endtask

  task automatic reset_mid_issue;
    for (int i = 0; i < BURST; i++) begin
      in_valid = 1'b1;
      in_state = {50{$urandom}};
      tick;
    end
    in_valid = 1'b0;
    core_gimme = 1'b1;
    tick;
    tick;
    repeat (5) tick;
    chk("rst_pre_sample", core_sample, 1);
    #2 rst_n = 1'b0;
    #1;
    exp_err = 1'b0;
    chk("rst_sample_async", core_sample, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_overrun, 0);
    core_gimme = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_busy", busy, 0);
    chk("rel_err", err_overrun, 0);
    chk("rel_out_valid", out_valid, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_sample", core_sample, 0);
    chk("reset_core_in", core_in, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", err_overrun, 0);
    rst_n = 1'b1;
    tick;

    run_burst(BURST, 0, 1'b1, 1, 1'b0, 1'b0);   // full directed burst
    run_burst(3, 0, 1'b1, 7, 1'b0, 1'b0);       // flush partial
    run_burst(BURST, 20, 1'b0, 0, 1'b0, 1'b0);  // gimme stall
    run_burst(BURST, 0, 1'b0, 0, 1'b1, 1'b0);   // gapped results + backpressure
    run_burst(5, 2, 1'b0, 0, 1'b1, 1'b1);       // overrun during fill
    reset_mid_issue();
    for (int t = 0; t < 12; t++)
      run_burst($urandom_range(1, BURST), $urandom_range(0, 4), 1'b0, 0,
                1'($urandom_range(0, 1)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
